// File: rtl/cryptoveril_pipe.sv
// cryptoveril_pipe: keyed mixing pipeline, one registered round per stage,
// ROUNDS stages deep, elastic valid/ready handshake at both ends.
//
// Each beat carries its own key down the pipe. The key is replicated to
// DATA_W bits, XORed in with a per-round rotation, the word is rotated by a
// key- and round-dependent amount, and the expanded key is then added back
// using ones'-complement (end-around carry) addition.
//
// Optional build macro: CRYPTOVERIL_STATS_EN
//   When defined, the block gains two 32-bit counters on extra output ports:
//   beats_out (delivered results) and stall_cycles (results held back by
//   out_ready low). The datapath is identical with or without the macro.

module cryptoveril_pipe #(
   parameter int DATA_W = 16,
   parameter int KEY_W  = 5,
   parameter int ROUNDS = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [KEY_W-1:0]  in_key,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              busy
`ifdef CRYPTOVERIL_STATS_EN
   ,
   output logic [31:0]       beats_out,
   output logic [31:0]       stall_cycles
`endif
);

   // Number of key copies needed to cover at least DATA_W bits.
   localparam int KEY_REPS = (DATA_W + KEY_W - 1) / KEY_W;

   // Per-stage state: valid flag, mixed word so far, and the beat's key.
   logic [ROUNDS-1:0] valid_q;
   logic [ROUNDS-1:0] valid_d;
   logic [DATA_W-1:0] data_q [ROUNDS];
   logic [DATA_W-1:0] data_d [ROUNDS];
   logic [KEY_W-1:0]  key_q  [ROUNDS];
   logic [KEY_W-1:0]  key_d  [ROUNDS];

   // Source feeding each stage: the input port for stage 0, the previous
   // stage's registers for every later stage.
   logic [ROUNDS-1:0] src_valid;
   logic [DATA_W-1:0] src_data [ROUNDS];
   logic [KEY_W-1:0]  src_key  [ROUNDS];

   // load_en[i] is high when stage i may take a new value this cycle,
   // either because it is empty or because its current beat moves on.
   logic [ROUNDS-1:0] load_en;

   // Replicate the key until it spans the data width, keep the low bits.
   function automatic logic [DATA_W-1:0] expand_key(input logic [KEY_W-1:0] key);
      logic [KEY_REPS*KEY_W-1:0] rep;
      rep = {KEY_REPS{key}};
      return rep[DATA_W-1:0];
   endfunction

   // Rotate left by amt, where amt is already reduced below DATA_W.
   // The upper half of the doubled word shifted left is the rotation.
   function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] x,
                                              input int unsigned     amt);
      logic [2*DATA_W-1:0] dbl;
      dbl = {x, x} << amt;
      return dbl[2*DATA_W-1:DATA_W];
   endfunction

   // One mixing round r on word x with key k.
   // The final add folds the carry back into bit 0; because the sum of two
   // DATA_W-bit words is at most 2^(DATA_W+1)-2, the folded result always
   // fits in DATA_W bits.
   function automatic logic [DATA_W-1:0] mix_round(input logic [DATA_W-1:0] x,
                                                   input logic [KEY_W-1:0]  k,
                                                   input int unsigned       r);
      logic [DATA_W-1:0] k_exp;
      logic [DATA_W-1:0] t;
      logic [DATA_W-1:0] u;
      logic [DATA_W:0]   s;
      int unsigned       word_rot;
      int unsigned       key_rot;
      k_exp    = expand_key(k);
      key_rot  = r % DATA_W;
      t        = x ^ rotl(k_exp, key_rot);
      word_rot = (32'(k) + r) % DATA_W;
      u        = rotl(t, word_rot);
      s        = {1'b0, u} + {1'b0, k_exp};
      return s[DATA_W-1:0] + {{(DATA_W-1){1'b0}}, s[DATA_W]};
   endfunction

   // Backpressure chain: walk from the output back to the input so a stall
   // at the output reaches every stage in the same cycle.
   always_comb begin : ready_chain
      logic down_ready;
      load_en    = '0;
      down_ready = out_ready;
      for (int i = ROUNDS - 1; i >= 0; i--) begin
         down_ready = ~valid_q[i] | down_ready;
         load_en[i] = down_ready;
      end
   end

   // Wire up what each stage would load: the port for stage 0, otherwise
   // the stage in front of it.
   always_comb begin
      src_valid    = '0;
      src_valid[0] = in_valid;
      src_data[0]  = in_data;
      src_key[0]   = in_key;
      for (int i = 1; i < ROUNDS; i++) begin
         src_valid[i] = valid_q[i-1];
         src_data[i]  = data_q[i-1];
         src_key[i]   = key_q[i-1];
      end
   end

   // Next state of every stage. A loading stage takes the upstream valid
   // flag; data and key are only overwritten by a real beat, so an empty
   // output keeps showing its last word.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      key_d   = key_q;
      for (int i = 0; i < ROUNDS; i++) begin
         if (load_en[i]) begin
            valid_d[i] = src_valid[i];
            if (src_valid[i]) begin
               data_d[i] = mix_round(src_data[i], src_key[i], i);
               key_d[i]  = src_key[i];
            end
         end
      end
   end

   // Stage registers; reset empties the pipe and clears every word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < ROUNDS; i++) begin
            data_q[i] <= '0;
            key_q[i]  <= '0;
         end
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         key_q   <= key_d;
      end
   end

   assign in_ready  = load_en[0];
   assign out_valid = valid_q[ROUNDS-1];
   assign out_data  = data_q[ROUNDS-1];
   assign busy      = |valid_q;

`ifdef CRYPTOVERIL_STATS_EN
   logic [31:0] beats_q;
   logic [31:0] beats_d;
   logic [31:0] stall_q;
   logic [31:0] stall_d;

   // Count delivered results and cycles where a result waits on the sink;
   // both counters simply wrap.
   always_comb begin
      beats_d = beats_q;
      stall_d = stall_q;
      if (out_valid & out_ready) begin
         beats_d = beats_q + 32'd1;
      end
      if (out_valid & ~out_ready) begin
         stall_d = stall_q + 32'd1;
      end
   end

   // Statistics registers, cleared together with the pipeline.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beats_q <= '0;
         stall_q <= '0;
      end else begin
         beats_q <= beats_d;
         stall_q <= stall_d;
      end
   end

   assign beats_out    = beats_q;
   assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_cryptoveril_pipe.sv
// Testbench for cryptoveril_pipe. Two instances share clock and reset:
// unit 0 uses the default three-round configuration, unit 1 is a single
// round deep so individual round results can be checked directly.
// Expected results come from a bit-level reference model and hand-derived
// constants, queued when a beat is accepted and compared when it emerges.

module tb_cryptoveril_pipe;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
   logic [15:0] a_in_data, a_out_data;
   logic [4:0]  a_in_key;
   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
   logic [15:0] b_in_data, b_out_data;
   logic [4:0]  b_in_key;
`ifdef CRYPTOVERIL_STATS_EN
   logic [31:0] a_beats, a_stalls, b_beats, b_stalls;
`endif

   cryptoveril_pipe #(.DATA_W(16), .KEY_W(5), .ROUNDS(3)) dut_a (
      .clk(clk), .rst(rst),
      .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_data(a_in_data), .in_key(a_in_key),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_data(a_out_data), .busy(a_busy)
`ifdef CRYPTOVERIL_STATS_EN
      , .beats_out(a_beats), .stall_cycles(a_stalls)
`endif
   );

   cryptoveril_pipe #(.DATA_W(16), .KEY_W(5), .ROUNDS(1)) dut_b (
      .clk(clk), .rst(rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_data(b_in_data), .in_key(b_in_key),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_data(b_out_data), .busy(b_busy)
`ifdef CRYPTOVERIL_STATS_EN
      , .beats_out(b_beats), .stall_cycles(b_stalls)
`endif
   );

   int vectors     = 0;
   int miscompares = 0;

   logic [15:0] sb_a [$];
   logic [15:0] sb_b [$];

   typedef struct {
      logic [15:0] data;
      logic [4:0]  key;
      logic [15:0] expected;
   } vec_t;

   vec_t vec_table [8];

   logic [15:0] bp_d [5];
   logic [4:0]  bp_k [5];

   // Bit-by-bit rotate left, independent of any shifter formulation.
   function automatic logic [15:0] ref_rotl(input logic [15:0] x, input int n);
      logic [15:0] y;
      y = '0;
      for (int i = 0; i < 16; i++) y[(i + n) % 16] = x[i];
      return y;
   endfunction

   // Reference model of the whole mix for a given number of rounds.
   function automatic logic [15:0] model(input logic [15:0] x_in,
                                         input logic [4:0]  k,
                                         input int          rounds);
      logic [15:0] kx, t, u, x;
      int          sum;
      x = x_in;
      for (int i = 0; i < 16; i++) kx[i] = k[i % 5];
      for (int r = 0; r < rounds; r++) begin
         t   = x ^ ref_rotl(kx, r % 16);
         u   = ref_rotl(t, ({27'd0, k} + r) % 16);
         sum = {16'd0, u} + {16'd0, kx};
         if (sum >= 65536) sum = sum - 65536 + 1;
         x = sum[15:0];
      end
      return x;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Offer one beat on a unit and hold it until accepted; the expected
   // result is queued on the cycle the handshake is seen.
   task automatic applyStimulus(input int unit, input logic [15:0] data,
                                input logic [4:0] key, input logic [15:0] expected);
      bit accepted = 1'b0;
      if (unit == 0) begin
         a_in_valid = 1'b1; a_in_data = data; a_in_key = key;
      end else begin
         b_in_valid = 1'b1; b_in_data = data; b_in_key = key;
      end
      for (int c = 0; c < 50 && !accepted; c++) begin
         @(negedge clk);
         if ((unit == 0 && a_in_ready) || (unit == 1 && b_in_ready)) begin
            accepted = 1'b1;
            if (unit == 0) sb_a.push_back(expected);
            else           sb_b.push_back(expected);
         end
         @(posedge clk); #1;
      end
      if (unit == 0) begin
         a_in_valid = 1'b0; a_in_data = 16'($urandom); a_in_key = 5'($urandom);
      end else begin
         b_in_valid = 1'b0; b_in_data = 16'($urandom); b_in_key = 5'($urandom);
      end
      if (!accepted) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL accept_timeout unit %0d: beat 0x%0h not accepted within 50 cycles", unit, data);
      end
   endtask

   // Wait until every queued result has come out, bounded.
   task automatic drain();
      int c = 0;
      while ((sb_a.size() != 0 || sb_b.size() != 0) && c < 100) begin
         @(posedge clk); #1;
         c++;
      end
      if (sb_a.size() != 0 || sb_b.size() != 0) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL drain_timeout: %0d/%0d results outstanding, expected 0",
                  sb_a.size(), sb_b.size());
      end
   endtask

   // Output monitors: compare every delivered beat against the queue head.
   always @(negedge clk) begin
      if (!rst && a_out_valid && a_out_ready) begin
         if (sb_a.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL a_unexpected_beat: got 0x%0h, expected no output", a_out_data);
         end else begin
            checkOutput("a_out_data", {16'd0, a_out_data}, {16'd0, sb_a.pop_front()});
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && b_out_valid && b_out_ready) begin
         if (sb_b.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL b_unexpected_beat: got 0x%0h, expected no output", b_out_data);
         end else begin
            checkOutput("b_out_data", {16'd0, b_out_data}, {16'd0, sb_b.pop_front()});
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1;
      a_in_valid = 1'b0; a_in_data = '0; a_in_key = '0; a_out_ready = 1'b1;
      b_in_valid = 1'b0; b_in_data = '0; b_in_key = '0; b_out_ready = 1'b1;

      // Reset state of both units
      #2;
      checkOutput("rst_a_out_valid", {31'd0, a_out_valid}, 0);
      checkOutput("rst_a_out_data",  {16'd0, a_out_data}, 0);
      checkOutput("rst_a_busy",      {31'd0, a_busy}, 0);
      checkOutput("rst_a_in_ready",  {31'd0, a_in_ready}, 1);
      checkOutput("rst_b_out_valid", {31'd0, b_out_valid}, 0);
      checkOutput("rst_b_in_ready",  {31'd0, b_in_ready}, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("post_rst_a_in_ready", {31'd0, a_in_ready}, 1);
`ifdef CRYPTOVERIL_STATS_EN
      checkOutput("rst_beats_out",    a_beats, 0);
      checkOutput("rst_stall_cycles", a_stalls, 0);
`endif

      // Single-round vectors: key expansion, plain add, end-around carry
      vec_table[0] = '{16'h0000, 5'h01, 16'h8C64};
      vec_table[1] = '{16'hFFFF, 5'h01, 16'h7BDE};
      vec_table[2] = '{16'h1234, 5'h00, 16'h1234};
      for (int i = 3; i < 8; i++) begin
         vec_table[i].data     = 16'($urandom);
         vec_table[i].key      = 5'($urandom);
         vec_table[i].expected = model(vec_table[i].data, vec_table[i].key, 1);
      end
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1, vec_table[i].data, vec_table[i].key, vec_table[i].expected);
      end
      drain();

      // Latency through three rounds, rotate-only path with key 0
      applyStimulus(0, 16'h1234, 5'h00, 16'h91A0);
      @(negedge clk);
      checkOutput("lat_cycle1_out_valid", {31'd0, a_out_valid}, 0);
      checkOutput("lat_cycle1_busy",      {31'd0, a_busy}, 1);
      @(negedge clk);
      checkOutput("lat_cycle2_out_valid", {31'd0, a_out_valid}, 0);
      @(negedge clk);
      checkOutput("lat_cycle3_out_valid", {31'd0, a_out_valid}, 1);
      @(posedge clk); #1;
      drain();

      // Backpressure: sink stalled while five beats are offered
      for (int i = 0; i < 5; i++) begin
         bp_d[i] = 16'($urandom);
         bp_k[i] = 5'($urandom);
      end
      a_out_ready = 1'b0;
      for (int i = 0; i < 3; i++) applyStimulus(0, bp_d[i], bp_k[i], model(bp_d[i], bp_k[i], 3));
      fork
         begin
            applyStimulus(0, bp_d[3], bp_k[3], model(bp_d[3], bp_k[3], 3));
            applyStimulus(0, bp_d[4], bp_k[4], model(bp_d[4], bp_k[4], 3));
         end
         begin
            for (int c = 0; c < 7; c++) begin
               @(negedge clk);
               checkOutput("bp_in_ready_low", {31'd0, a_in_ready}, 0);
               checkOutput("bp_out_data_hold", {16'd0, a_out_data},
                           {16'd0, model(bp_d[0], bp_k[0], 3)});
               @(posedge clk); #1;
            end
            a_out_ready = 1'b1;
            for (int c = 0; c < 5; c++) begin
               @(negedge clk);
               checkOutput("stream_no_gap", {31'd0, a_out_valid}, 1);
            end
         end
      join
      @(posedge clk); #1;
      drain();

      // Reset pulse in the middle of a back-to-back stream
      for (int i = 0; i < 4; i++) begin
         logic [15:0] d;
         logic [4:0]  k;
         d = 16'($urandom);
         k = 5'($urandom);
         applyStimulus(0, d, k, model(d, k, 3));
      end
      checkOutput("midrst_busy_before", {31'd0, a_busy}, 1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("midrst_out_valid", {31'd0, a_out_valid}, 0);
      checkOutput("midrst_busy",      {31'd0, a_busy}, 0);
      checkOutput("midrst_out_data",  {16'd0, a_out_data}, 0);
      checkOutput("midrst_in_ready",  {31'd0, a_in_ready}, 1);
      sb_a.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checkOutput("no_stale_beat", {31'd0, a_out_valid}, 0);
         @(posedge clk); #1;
      end
`ifdef CRYPTOVERIL_STATS_EN
      checkOutput("midrst_beats_out",    a_beats, 0);
      checkOutput("midrst_stall_cycles", a_stalls, 0);
`endif

      // Four beats with exactly two stalled output cycles
      a_out_ready = 1'b0;
      for (int i = 0; i < 3; i++) applyStimulus(0, bp_d[i], bp_k[i], model(bp_d[i], bp_k[i], 3));
      repeat (2) @(posedge clk);
      #1;
      a_out_ready = 1'b1;
      applyStimulus(0, bp_d[4], bp_k[4], model(bp_d[4], bp_k[4], 3));
      drain();
`ifdef CRYPTOVERIL_STATS_EN
      checkOutput("stats_beats_out",    a_beats, 4);
      checkOutput("stats_stall_cycles", a_stalls, 2);
`endif
      checkOutput("final_busy", {31'd0, a_busy}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
